// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared multicycle multiply/divide unit.
// Optional WAIT watchdog is enabled with `define MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        hit;
  logic        is_div;
  logic [4:0]  rd_q;
  logic        start_mult_q, start_div_q;
  logic        timed_out;

  assign hit = in_valid && (opcode == 5'd0) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Counter is zero on the first WAIT cycle, so it reads TIMEOUT-1 on the last allowed one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
`else
  // Watchdog compiled out: the comparison is always false for any legal TIMEOUT.
  assign timed_out = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = hit;
        if (hit) state_nxt = ISSUE;
      end
      ISSUE: begin
        stall     = 1'b1;
        state_nxt = flush ? IDLE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (flush)                          state_nxt = DRAIN;
        else if (md_result_rdy || timed_out) state_nxt = WB;
      end
      WB: state_nxt = IDLE;
      DRAIN: begin
        stall = hit;
        if (md_result_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The start pulse is registered but can still be squashed by a flush during ISSUE.
  assign md_ctrl_mult = start_mult_q && !flush;
  assign md_ctrl_div  = start_div_q && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      md_op_a      <= '0;
      md_op_b      <= '0;
      rd_q         <= '0;
      is_div       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      start_mult_q <= (state == IDLE) && hit && !alu_op[0];
      start_div_q  <= (state == IDLE) && hit && alu_op[0];
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      if ((state == IDLE) && hit) begin
        md_op_a <= operand_a;
        md_op_b <= operand_b;
        rd_q    <= rd;
        is_div  <= alu_op[0];
      end
      // Exceptions and watchdog expiry redirect the write to $r30 with a cause code.
      if ((state == WAIT) && !flush) begin
        if ((md_result_rdy && md_exception) || (!md_result_rdy && timed_out)) begin
          wb_valid <= 1'b1;
          wb_rd    <= 5'd30;
          wb_data  <= is_div ? 32'd5 : 32'd4;
        end else if (md_result_rdy) begin
          wb_valid <= (rd_q != 5'd0);
          wb_rd    <= rd_q;
          wb_data  <= md_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
// Watchdog vectors run only when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_ctrl;

  localparam int         TB_TIMEOUT = 8;
  localparam logic [4:0] MUL_OP     = 5'b00110;
  localparam logic [4:0] DIV_OP     = 5'b00111;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd;
  logic [31:0] operand_a, operand_b;
  logic        flush;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_op_a, md_op_b;
  logic        md_result_rdy, md_exception;
  logic [31:0] md_result;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .alu_op(alu_op), .rd(rd), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_op_a(md_op_a), .md_op_b(md_op_b), .md_result_rdy(md_result_rdy),
    .md_exception(md_exception), .md_result(md_result), .stall(stall),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  int          cycIdx, stallCnt, multCnt, divCnt, wbCnt, wbAt;
  logic [31:0] wbRdSeen, wbDataSeen, opASeen, opBSeen;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearTally();
    cycIdx = 0; stallCnt = 0; multCnt = 0; divCnt = 0; wbCnt = 0; wbAt = -1;
    wbRdSeen = '0; wbDataSeen = '0; opASeen = '0; opBSeen = '0;
  endtask

  // Drive one cycle of inputs at the falling edge, then tally what the DUT shows.
  task automatic applyStimulus(input logic v, input logic [4:0] aop, input logic [4:0] rdv,
                               input logic [31:0] a, input logic [31:0] b, input logic fl,
                               input logic rdy, input logic exc, input logic [31:0] res);
    @(negedge clock);
    in_valid = v; opcode = 5'd0; alu_op = aop; rd = rdv; operand_a = a; operand_b = b;
    flush = fl; md_result_rdy = rdy; md_exception = exc; md_result = res;
    #1;
    if (stall) stallCnt++;
    if (md_ctrl_mult) multCnt++;
    if (md_ctrl_div) divCnt++;
    if (md_ctrl_mult || md_ctrl_div) begin
      opASeen = md_op_a;
      opBSeen = md_op_b;
    end
    if (wb_valid) begin
      wbCnt++;
      wbAt       = cycIdx;
      wbRdSeen   = 32'(wb_rd);
      wbDataSeen = wb_data;
    end
    cycIdx++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Detect, issue, lat WAIT cycles (ready on the last), WB, one trailing IDLE.
  task automatic runOp(input logic isDiv, input logic [4:0] rdv, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic exc, input logic [31:0] res);
    clearTally();
    applyStimulus(1'b1, isDiv ? DIV_OP : MUL_OP, rdv, a, b, 1'b0, 1'b0, 1'b0, 32'd0);
    idleCycle();
    for (int i = 1; i <= lat; i++)
      applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, (i == lat), exc, res);
    idleCycle();
    idleCycle();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; opcode = '0; alu_op = '0; rd = '0;
    operand_a = '0; operand_b = '0; flush = 1'b0;
    md_result_rdy = 1'b0; md_exception = 1'b0; md_result = '0;
    clearTally();
    #12;
    checkOutput("rst.stall", 32'(stall), 0);
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.wb_valid", 32'(wb_valid), 0);
    checkOutput("rst.wb_rd", 32'(wb_rd), 0);
    checkOutput("rst.wb_data", wb_data, 0);
    checkOutput("rst.start", 32'({md_ctrl_mult, md_ctrl_div}), 0);
    checkOutput("rst.op_a", md_op_a, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // mul $r3 = 6*7, ready 4 cycles after start.
    runOp(1'b0, 5'd3, 32'd6, 32'd7, 4, 1'b0, 32'd42);
    checkOutput("mul.pulses", 32'(multCnt), 1);
    checkOutput("mul.div_pulses", 32'(divCnt), 0);
    checkOutput("mul.stall_cycles", 32'(stallCnt), 6);
    checkOutput("mul.op_a", opASeen, 6);
    checkOutput("mul.op_b", opBSeen, 7);
    checkOutput("mul.wb_count", 32'(wbCnt), 1);
    checkOutput("mul.wb_cycle", 32'(wbAt), 6);
    checkOutput("mul.wb_rd", wbRdSeen, 3);
    checkOutput("mul.wb_data", wbDataSeen, 42);
    checkOutput("mul.busy_after", 32'(busy), 0);

    // Minimum latency: ready in the first WAIT cycle.
    runOp(1'b0, 5'd9, 32'd2, 32'd3, 1, 1'b0, 32'd6);
    checkOutput("fast.wb_cycle", 32'(wbAt), 3);
    checkOutput("fast.wb_rd", wbRdSeen, 9);
    checkOutput("fast.wb_data", wbDataSeen, 6);

    // div $r5 = 9/0 with exception.
    runOp(1'b1, 5'd5, 32'd9, 32'd0, 2, 1'b1, 32'hDEAD);
    checkOutput("divx.div_pulses", 32'(divCnt), 1);
    checkOutput("divx.mul_pulses", 32'(multCnt), 0);
    checkOutput("divx.stall_cycles", 32'(stallCnt), 4);
    checkOutput("divx.wb_count", 32'(wbCnt), 1);
    checkOutput("divx.wb_rd", wbRdSeen, 30);
    checkOutput("divx.wb_data", wbDataSeen, 5);

    // mul $r0: silent on success, $r30 on exception.
    runOp(1'b0, 5'd0, 32'd3, 32'd4, 1, 1'b0, 32'd12);
    checkOutput("r0.wb_count", 32'(wbCnt), 0);
    checkOutput("r0.busy_after", 32'(busy), 0);
    runOp(1'b0, 5'd0, 32'd3, 32'd4, 3, 1'b1, 32'd0);
    checkOutput("r0x.wb_count", 32'(wbCnt), 1);
    checkOutput("r0x.wb_rd", wbRdSeen, 30);
    checkOutput("r0x.wb_data", wbDataSeen, 4);

    // Flush in ISSUE, then an unsolicited ready in IDLE.
    clearTally();
    applyStimulus(1'b1, MUL_OP, 5'd4, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("fli.mult", 32'(md_ctrl_mult), 0);
    checkOutput("fli.stall", 32'(stall), 1);
    idleCycle();
    checkOutput("fli.busy", 32'(busy), 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd55);
    idleCycle();
    checkOutput("fli.busy_after_rdy", 32'(busy), 0);
    checkOutput("fli.wb_count", 32'(wbCnt), 0);
    checkOutput("fli.pulses", 32'(multCnt), 0);

    // Flush in WAIT, drain, with a div waiting behind it.
    clearTally();
    applyStimulus(1'b1, MUL_OP, 5'd7, 32'd10, 32'd11, 1'b0, 1'b0, 1'b0, 32'd0);
    idleCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd66);
    checkOutput("flw.stall_wait", 32'(stall), 1);
    idleCycle();
    checkOutput("flw.stall_drain", 32'(stall), 0);
    checkOutput("flw.busy_drain", 32'(busy), 1);
    applyStimulus(1'b1, DIV_OP, 5'd8, 32'd20, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("flw.stall_hit_drain", 32'(stall), 1);
    applyStimulus(1'b1, DIV_OP, 5'd8, 32'd20, 32'd4, 1'b0, 1'b1, 1'b0, 32'd99);
    applyStimulus(1'b1, DIV_OP, 5'd8, 32'd20, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("flw.idle_busy", 32'(busy), 0);
    checkOutput("flw.idle_stall", 32'(stall), 1);
    checkOutput("flw.no_div_yet", 32'(divCnt), 0);
    idleCycle();
    checkOutput("flw.div_issue", 32'(md_ctrl_div), 1);
    checkOutput("flw.op_a", md_op_a, 20);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd5);
    idleCycle();
    idleCycle();
    checkOutput("flw.wb_count", 32'(wbCnt), 1);
    checkOutput("flw.wb_cycle", 32'(wbAt), 9);
    checkOutput("flw.wb_rd", wbRdSeen, 8);
    checkOutput("flw.wb_data", wbDataSeen, 5);
    checkOutput("flw.mult_pulses", 32'(multCnt), 1);

    // Asynchronous reset while in WAIT.
    clearTally();
    applyStimulus(1'b1, MUL_OP, 5'd6, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
    idleCycle();
    idleCycle();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("arst.busy", 32'(busy), 0);
    checkOutput("arst.stall", 32'(stall), 0);
    checkOutput("arst.op_a", md_op_a, 0);
    checkOutput("arst.wb_valid", 32'(wb_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd9);
    idleCycle();
    idleCycle();
    checkOutput("arst.wb_count", 32'(wbCnt), 0);
    checkOutput("arst.busy_after", 32'(busy), 0);

`ifdef MULTDIV_TIMEOUT_EN
    // Silent unit: WB on the 9th cycle after entering WAIT, late ready ignored.
    clearTally();
    applyStimulus(1'b1, MUL_OP, 5'd12, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) idleCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd77);
    idleCycle();
    idleCycle();
    checkOutput("wdog.wb_count", 32'(wbCnt), 1);
    checkOutput("wdog.wb_cycle", 32'(wbAt), 10);
    checkOutput("wdog.wb_rd", wbRdSeen, 30);
    checkOutput("wdog.wb_data", wbDataSeen, 4);
    checkOutput("wdog.busy_after", 32'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
